// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: funct3 encodings, FSM states and writeback mux selects.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } st_funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_LD  = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_hs_load_extend.sv
// Picks the addressed byte/half out of a raw memory word and sign- or zero-extends it.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM->WB pipeline stage: data-memory handshake with timeout, store lane steering,
// load alignment and the registered WB payload.
//   state   | meaning
//   ST_IDLE | no access outstanding; request issued combinationally for a new mem op
//   ST_WAIT | request held from latched addr/data/be until ack or timeout
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_HEX = 8,
  parameter int HEX_W   = 7,
  parameter int TMO_W   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  input  logic [XLEN-1:0]          i_inst,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_alu_data,
  input  logic [XLEN-1:0]          i_rs2_data,
  input  logic                     i_lsu_wren,
  input  logic                     i_lsu_rden,
  input  logic [2:0]               i_slt_sl,
  input  logic [1:0]               i_wb_sel,
  input  logic                     i_rd_wren,
  input  logic [NUM_HEX*HEX_W-1:0] i_io_hex,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic [XLEN-1:0]          o_dmem_addr,
  output logic [XLEN-1:0]          o_dmem_wdata,
  output logic [3:0]               o_dmem_be,
  input  logic                     i_dmem_ack,
  input  logic [XLEN-1:0]          i_dmem_rdata,
  output logic [4:0]               o_fwd_rd_addr,
  output logic                     o_fwd_valid,
  output logic                     o_wb_valid,
  output logic [XLEN-1:0]          o_wb_pc_add4,
  output logic [XLEN-1:0]          o_wb_alu_data,
  output logic [XLEN-1:0]          o_wb_ld_data,
  output logic [XLEN-1:0]          o_wb_inst,
  output logic [1:0]               o_wb_sel,
  output logic                     o_wb_rd_wren,
  output logic [NUM_HEX*HEX_W-1:0] o_io_hex,
  output logic                     o_misalign,
  output logic                     o_bus_err
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q;
  logic             flush_q;
  logic [XLEN-1:0]  addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [2:0]       f3_q;

  logic             mem_op, misaligned, ack, timeout, done, mis_drop, wb_valid_d;
  logic             in_wait;
  logic [3:0]       st_be;
  logic [XLEN-1:0]  st_wdata, ld_ext;

  assign mem_op     = i_valid & (i_lsu_wren | i_lsu_rden);
  assign misaligned = is_misaligned(i_slt_sl, i_alu_data[1:0]);
  assign in_wait    = (state_q == ST_WAIT);

  assign o_fwd_rd_addr = i_inst[11:7];
  assign o_fwd_valid   = i_valid & i_rd_wren & (i_inst[11:7] != 5'd0) & ~i_lsu_rden;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_rs2_data;
    case (i_slt_sl)
      F3_SB: begin
        st_be    = 4'b0001 << i_alu_data[1:0];
        st_wdata = {(XLEN/8){i_rs2_data[7:0]}};
      end
      F3_SH: begin
        st_be    = 4'b0011 << i_alu_data[1:0];
        st_wdata = {(XLEN/16){i_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // in WAIT the bus sees the values captured at issue, not the live EX inputs
  assign o_dmem_addr  = in_wait ? {addr_q[XLEN-1:2], 2'b00} : {i_alu_data[XLEN-1:2], 2'b00};
  assign o_dmem_we    = in_wait ? we_q    : i_lsu_wren;
  assign o_dmem_wdata = in_wait ? wdata_q : st_wdata;
  assign o_dmem_be    = in_wait ? be_q    : st_be;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata   (i_dmem_rdata),
    .addr_lo (in_wait ? addr_q[1:0] : i_alu_data[1:0]),
    .funct3  (in_wait ? f3_q : i_slt_sl),
    .result  (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    o_dmem_req = 1'b0;
    ack        = 1'b0;
    timeout    = 1'b0;
    mis_drop   = 1'b0;
    done       = 1'b1;
    wb_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !i_flush) begin
          if (misaligned) begin
            mis_drop = 1'b1;
          end else begin
            o_dmem_req = 1'b1;
            ack        = i_dmem_ack;
            done       = i_dmem_ack;
            if (!i_dmem_ack) state_d = ST_WAIT;
          end
        end
        wb_valid_d = i_valid & ~i_flush & ~mis_drop;
      end
      ST_WAIT: begin
        o_dmem_req = 1'b1;
        ack        = i_dmem_ack;
        timeout    = !i_dmem_ack && (cnt_q == CNT_MAX);
        done       = ack | timeout;
        if (done) state_d = ST_IDLE;
        wb_valid_d = i_valid & ~flush_q & ~i_flush & ~timeout;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ready = done;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      o_wb_valid    <= 1'b0;
      o_wb_pc_add4  <= '0;
      o_wb_alu_data <= '0;
      o_wb_ld_data  <= '0;
      o_wb_inst     <= '0;
      o_wb_sel      <= '0;
      o_wb_rd_wren  <= 1'b0;
      o_io_hex      <= '0;
      o_misalign    <= 1'b0;
      o_bus_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_io_hex   <= i_io_hex;
      o_misalign <= mis_drop;
      if (timeout) o_bus_err <= 1'b1;

      if (!in_wait && state_d == ST_WAIT) begin
        cnt_q   <= TMO_W'(1);
        flush_q <= 1'b0;
        addr_q  <= i_alu_data;
        wdata_q <= st_wdata;
        be_q    <= st_be;
        we_q    <= i_lsu_wren;
        f3_q    <= i_slt_sl;
      end else if (in_wait) begin
        cnt_q   <= done ? '0 : cnt_q + TMO_W'(1);
        flush_q <= done ? 1'b0 : (flush_q | i_flush);
      end

      if (done) begin
        o_wb_valid    <= wb_valid_d;
        o_wb_rd_wren  <= wb_valid_d & i_rd_wren;
        o_wb_pc_add4  <= i_pc + XLEN'(4);
        o_wb_alu_data <= i_alu_data;
        o_wb_ld_data  <= ack ? ld_ext : '0;
        o_wb_inst     <= i_inst;
        o_wb_sel      <= i_wb_sel;
      end else begin
        o_wb_valid   <= 1'b0;
        o_wb_rd_wren <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: transaction-level model checked every cycle plus literal pins.
module tb_mem_stage_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, valid, flush, wren, rden, rdw, ack;
  logic [31:0] inst, pc, alu, rs2, rdata;
  logic [2:0]  f3;
  logic [1:0]  sel;
  logic [55:0] hex;

  logic        o_ready, o_dmem_req, o_dmem_we, o_fwd_valid, o_wb_valid, o_wb_rd_wren;
  logic        o_misalign, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_inst;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_fwd_rd_addr;
  logic [1:0]  o_wb_sel;
  logic [55:0] o_io_hex;

  mem_stage_hs dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(o_ready), .i_flush(flush),
    .i_inst(inst), .i_pc(pc), .i_alu_data(alu), .i_rs2_data(rs2),
    .i_lsu_wren(wren), .i_lsu_rden(rden), .i_slt_sl(f3), .i_wb_sel(sel), .i_rd_wren(rdw),
    .i_io_hex(hex), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(ack), .i_dmem_rdata(rdata),
    .o_fwd_rd_addr(o_fwd_rd_addr), .o_fwd_valid(o_fwd_valid), .o_wb_valid(o_wb_valid),
    .o_wb_pc_add4(o_wb_pc_add4), .o_wb_alu_data(o_wb_alu_data), .o_wb_ld_data(o_wb_ld_data),
    .o_wb_inst(o_wb_inst), .o_wb_sel(o_wb_sel), .o_wb_rd_wren(o_wb_rd_wren),
    .o_io_hex(o_io_hex), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  bit          m_ready, m_req, m_wbv, m_rdw, m_bus_err, m_mis, m_ldchk;
  logic [31:0] m_pc4, m_alu, m_inst, m_ld;
  logic [1:0]  m_sel;
  logic [55:0] m_hex;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_on = 1'b0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit model_mis(input logic [2:0] f, input logic [31:0] a);
    return (a % size_bytes(f)) != 0;
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] f);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f)
      3'b000:  return (v & 32'hFF)   | (v[7]  ? 32'hFFFFFF00 : 32'h0);
      3'b001:  return (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
      3'b100:  return v & 32'hFF;
      3'b101:  return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int n;
    n = size_bytes(f);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = size_bytes(f);
    w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", o_ready, m_ready);
      chk("req", o_dmem_req, m_req);
      if (m_req) begin
        last_be    = o_dmem_be;
        last_wdata = o_dmem_wdata;
        chk("addr", o_dmem_addr, {alu[31:2], 2'b00});
        chk("we", o_dmem_we, wren);
        if (wren) begin
          chk("be", o_dmem_be, model_be(f3, alu));
          chk("wdata", o_dmem_wdata, model_wdata(f3, rs2));
        end
      end
      chk("fwd_rd", o_fwd_rd_addr, inst[11:7]);
      chk("fwd_valid", o_fwd_valid, valid & rdw & (inst[11:7] != 5'd0) & ~rden);
      chk("wb_valid", o_wb_valid, m_wbv);
      chk("wb_rd_wren", o_wb_rd_wren, m_rdw);
      chk("wb_pc4", o_wb_pc_add4, m_pc4);
      chk("wb_alu", o_wb_alu_data, m_alu);
      chk("wb_inst", o_wb_inst, m_inst);
      chk("wb_sel", o_wb_sel, m_sel);
      if (m_ldchk) chk("wb_ld", o_wb_ld_data, m_ld);
      chk("bus_err", o_bus_err, m_bus_err);
      chk("misalign", o_misalign, m_mis);
      chk("io_hex", o_io_hex, m_hex);
    end
  end

  // One clock: expectations for this cycle, then the registered result of the edge.
  task automatic step(input bit rdy, input bit req, input bit wbv, input bit ldchk,
                      input logic [31:0] ld, input bit tmo, input bit mis);
    m_ready = rdy;
    m_req   = req;
    @(posedge clk);
    if (!reset_n) begin
      m_wbv = 0; m_rdw = 0; m_bus_err = 0; m_mis = 0; m_ldchk = 1;
      m_pc4 = '0; m_alu = '0; m_inst = '0; m_ld = '0; m_sel = '0; m_hex = '0;
    end else begin
      m_hex = hex;
      m_mis = mis;
      if (tmo) m_bus_err = 1;
      if (rdy) begin
        m_wbv = wbv; m_rdw = wbv & rdw;
        m_pc4 = pc + 32'd4; m_alu = alu; m_inst = inst; m_sel = sel;
        m_ld = ld; m_ldchk = ldchk;
      end else begin
        m_wbv = 0; m_rdw = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, 0, 0);
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store; dly = req cycles before ack (-1 never); fl_at = flush cycle
  task automatic do_op(input int kind, input logic [2:0] f3v, input logic [31:0] a,
                       input logic [31:0] rs2v, input logic [31:0] rdv, input logic [31:0] pcv,
                       input logic [31:0] instv, input int dly, input int fl_at);
    bit mem, mis, issue, tmo, flushed, last;
    int waits;
    logic [31:0] ld;
    valid = 1; wren = (kind == 2); rden = (kind == 1); f3 = f3v; alu = a; rs2 = rs2v;
    rdata = rdv; pc = pcv; inst = instv; rdw = (kind != 2); sel = (kind == 1) ? 2'd1 : 2'd0;
    mem   = (kind != 0);
    mis   = mem && model_mis(f3v, a);
    issue = mem && !mis && (fl_at != 0);
    tmo   = issue && (dly < 0 || dly > 15);
    waits = !issue ? 0 : (tmo ? 15 : dly);
    ld    = (kind == 1 && !tmo) ? model_ld(rdv, a, f3v) : 32'h0;
    flushed = 0;
    for (int c = 0; c <= waits; c++) begin
      ack   = issue && (c == dly);
      flush = (c == fl_at);
      if (flush) flushed = 1;
      last  = (c == waits);
      step(last, issue, last && !flushed && !mis && !tmo, last && ((kind == 1 && issue) || tmo),
           ld, last && tmo, mis && (fl_at != 0));
    end
    valid = 0; ack = 0; flush = 0; wren = 0; rden = 0;
    m_ready = 1; m_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [55:0] base;
    reset_n = 0; valid = 0; flush = 0; wren = 0; rden = 0; rdw = 0; ack = 0;
    inst = '0; pc = '0; alu = '0; rs2 = '0; rdata = '0; f3 = '0; sel = '0; hex = '0;
    #1;
    step(1, 0, 0, 0, '0, 0, 0);
    reset_n = 1;
    chk_on  = 1;
    @(negedge clk);
    chk("lit_rst_wbv", o_wb_valid, 0);
    chk("lit_rst_pc4", o_wb_pc_add4, 0);
    #1;
    idle(1);

    do_op(0, 3'b000, 32'h55, 0, 0, 32'h100, 32'h00A00093, 0, -1);
    @(negedge clk);
    chk("lit_alu_pc4", o_wb_pc_add4, 32'h104);
    chk("lit_alu_valid", o_wb_valid, 1);
    #1;

    do_op(1, 3'b010, 32'h20, 0, 32'hDEADBEEF, 32'h104, 32'h02002083, 3, -1);
    @(negedge clk);
    chk("lit_lw", o_wb_ld_data, 32'hDEADBEEF);
    #1;

    do_op(1, 3'b000, 32'h23, 0, 32'h80FF0000, 32'h108, 32'h02300103, 0, -1);
    @(negedge clk);
    chk("lit_lb", o_wb_ld_data, 32'hFFFFFF80);
    #1;

    do_op(1, 3'b101, 32'h22, 0, 32'h80FF0000, 32'h10C, 32'h02205183, 1, -1);
    @(negedge clk);
    chk("lit_lhu", o_wb_ld_data, 32'h000080FF);
    #1;
    idle(1);

    do_op(2, 3'b001, 32'h12, 32'h0000ABCD, 0, 32'h110, 32'h00B01923, 0, -1);
    chk("lit_sh_be", last_be, 4'b1100);
    chk("lit_sh_wdata", last_wdata[31:16], 16'hABCD);
    do_op(2, 3'b000, 32'h11, 32'h12345677, 0, 32'h114, 32'h00B008A3, 2, -1);
    chk("lit_sb_be", last_be, 4'b0010);

    do_op(2, 3'b010, 32'h13, 32'h11223344, 0, 32'h118, 32'h00B029A3, 0, -1);
    @(negedge clk);
    chk("lit_mis_pulse", o_misalign, 1);
    chk("lit_mis_bubble", o_wb_valid, 0);
    #1;
    idle(1);
    do_op(1, 3'b001, 32'h21, 0, 32'h1234, 32'h11C, 32'h02109083, 0, -1);
    idle(1);

    do_op(1, 3'b010, 32'h30, 0, 32'hCAFEF00D, 32'h120, 32'h03002083, -1, -1);
    @(negedge clk);
    chk("lit_tmo_err", o_bus_err, 1);
    chk("lit_tmo_bubble", o_wb_valid, 0);
    chk("lit_tmo_ld", o_wb_ld_data, 0);
    #1;
    do_op(1, 3'b010, 32'h34, 0, 32'h0BADCAFE, 32'h124, 32'h03402083, 15, -1);
    @(negedge clk);
    chk("lit_late_ack", o_wb_ld_data, 32'h0BADCAFE);
    #1;

    do_op(1, 3'b010, 32'h38, 0, 32'h5555AAAA, 32'h128, 32'h03802083, 4, 2);
    @(negedge clk);
    chk("lit_flush_bubble", o_wb_valid, 0);
    #1;
    do_op(2, 3'b010, 32'h3C, 32'h99, 0, 32'h12C, 32'h00B02E23, 0, 0);
    idle(1);

    do_op(0, 3'b000, 32'h7, 0, 0, 32'hFFFFFFFC, 32'h00100293, 0, -1);
    @(negedge clk);
    chk("lit_pc_wrap", o_wb_pc_add4, 32'h0);
    #1;

    base = 56'h0F1E2D3C4B5A69;
    hex = base;
    hex[27:21] = 7'h5A;
    idle(1);
    @(negedge clk);
    chk("lit_hex_d3", o_io_hex[27:21], 7'h5A);
    chk("lit_hex_lo", o_io_hex[20:0], base[20:0]);
    chk("lit_hex_hi", o_io_hex[55:28], base[55:28]);
    #1;

    valid = 1; rden = 1; wren = 0; f3 = 3'b010; alu = 32'h40; rdw = 1; sel = 2'd1;
    inst = 32'h04002083; pc = 32'h200; ack = 0;
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    reset_n = 0; valid = 0; rden = 0;
    step(0, 1, 0, 0, '0, 0, 0);
    reset_n = 1; ack = 1;
    m_ready = 1; m_req = 0;
    @(negedge clk);
    chk("lit_rstw_req", o_dmem_req, 0);
    chk("lit_rstw_wbv", o_wb_valid, 0);
    chk("lit_rstw_pc4", o_wb_pc_add4, 0);
    chk("lit_rstw_hex", o_io_hex, 0);
    chk("lit_rstw_err", o_bus_err, 0);
    #1;
    step(1, 0, 0, 0, '0, 0, 0);
    ack = 0;
    idle(2);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
